// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester bridge.
// Converts single-beat command requests into APB SETUP/ACCESS transfers,
// honours completer wait states, returns read data and error status, and
// aborts with a timeout error when the completer stalls too long.
// One transfer is outstanding at a time.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,  // ACCESS cycles with pready low before abort; 0 disables
  parameter int TO_W    = 8    // wait counter width; must hold TIMEOUT
) (
  input  logic                pclk,
  input  logic                presetn,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  // response side
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  // APB requester
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Abort fires at the end of the TIMEOUT-th stalled ACCESS cycle, i.e. when
  // the counter of previously stalled cycles equals TIMEOUT-1.
  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_t              r_state;
  logic [TO_W-1:0]     r_wait_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [DATA_W/8-1:0] r_pstrb;
  logic [2:0]          r_pprot;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;

  // Transfer sequencer: phase state, APB request registers and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    // NOTE: the address/data holding registers are reset too, because every
    // output must read 0 while in reset; plain storage arrays would not need it.
    if (!presetn) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge values of the others; this default makes rsp_valid a 1-cycle pulse.
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_pwrite   <= cmd_write;
            r_paddr    <= cmd_addr;
            r_pwdata   <= cmd_wdata;
            r_pstrb    <= cmd_write ? cmd_strb : '0;
            r_pprot    <= cmd_prot;
            r_wait_cnt <= '0;
            r_psel     <= 1'b1;
            r_state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (TO_EN && (r_wait_cnt == TO_LAST)) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (r_wait_cnt != TO_MAX) begin
            // Saturate rather than wrap so a disabled timeout never aliases.
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode directly from the state register.
  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester (initiator) that turns simple single-beat command requests from internal logic (test sequencer, CPU-side shim, DMA stub) into APB3/APB4 transfers toward completers such as the UART register block. It sequences IDLE/SETUP/ACCESS phases, honours completer wait states, captures read data and `pslverr`, and aborts with an error if the completer stalls beyond a programmable number of cycles. One transfer is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width (strobe width = `DATA_W/8`)
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout
- `TO_W`, 8, timeout counter width; must hold `TIMEOUT`

Ports:
- `pclk` in 1: single clock, all logic rising-edge
- `presetn` in 1: asynchronous active-low reset
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: command accepted when high with `cmd_valid`
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDR_W: target address
- `cmd_wdata` in DATA_W: write data
- `cmd_strb` in DATA_W/8: write byte strobes
- `cmd_prot` in 3: protection attributes
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_rdata` out DATA_W: read data (0 for writes and timeouts)
- `rsp_err` out 1: `pslverr` seen or timeout
- `rsp_timeout` out 1: completion was a timeout abort
- `busy` out 1: transfer in progress (SETUP or ACCESS)
- `psel`, `penable`, `pwrite` out 1 each; `paddr` out ADDR_W; `pwdata` out DATA_W; `pstrb` out DATA_W/8; `pprot` out 3
- `pready`, `pslverr` in 1 each; `prdata` in DATA_W

## Operation
- States: IDLE, SETUP, ACCESS (2-bit encoded, registered).
- IDLE: `cmd_ready`=1, `psel`=0, `penable`=0. On `cmd_valid`: latch write/addr/wdata/prot; `pstrb` latches `cmd_strb` on writes, forced 0 on reads; go SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally go ACCESS after one cycle.
- ACCESS: `psel`=1, `penable`=1. If `pready`=1: capture `prdata` (reads only, else 0) and `pslverr` into response regs, assert `rsp_valid` next cycle, go IDLE. If `pready`=0: increment wait counter; when counter reaches `TIMEOUT` (non-zero), go IDLE with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- `pslverr` is sampled only in the ACCESS cycle where `pready`=1; ignored otherwise.
- Wait counter clears on entry to SETUP; saturates, never wraps.
- `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot` held stable from SETUP through the completing ACCESS cycle and keep their last value in IDLE.
- `cmd_ready` = (state == IDLE); `busy` = not IDLE. Command inputs ignored outside IDLE.
- `rsp_rdata`/`rsp_err`/`rsp_timeout` hold until the next completion; `rsp_valid` is high exactly one cycle per transfer.
- Reset (any state, including mid-ACCESS): return to IDLE immediately; all outputs 0 except `cmd_ready`=1; in-flight transfer dropped with no response.

## Timing
- Command accepted at edge T -> SETUP in cycle T+1 -> ACCESS from T+2.
- Zero-wait completer: `pready` high in T+2 -> `rsp_valid` high in T+3, `cmd_ready` high in T+3; next command accepted at end of T+3. Throughput: one transfer per 3 cycles minimum, plus N cycles for N wait states.
- Timeout: with `pready` held low, abort edge is end of ACCESS cycle number `TIMEOUT`; `psel`/`penable` drop and `rsp_valid` rises in the following cycle.
- `rsp_valid` and `cmd_ready` high in the same cycle after every completion.
- All outputs registered or decoded only from state; no combinational path from `pready`/`prdata` to any output.

## Test plan
- Write `cmd_addr`=0x4, `cmd_wdata`=0x3D1, `cmd_strb`=0xF, `pready`=1 -> `psel` high T+1..T+2, `penable` high T+2 only, `pwdata`=0x3D1; `rsp_valid`=1, `rsp_err`=0 at T+3.
- Read 0x0 with `pready` low 2 cycles then high, `prdata`=0x5A -> `penable` high T+2..T+4, `pstrb`=0; `rsp_rdata`=0x5A at T+5.
- Write 0x3 with `pslverr`=1 on the ready cycle -> `rsp_err`=1, `rsp_timeout`=0; next command still accepted normally.
- `TIMEOUT`=4, `pready` stuck low -> 4 ACCESS cycles, then `psel`=0, `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- `cmd_valid` held high for three back-to-back writes, zero wait -> accepted every 3 cycles, `psel` low exactly one cycle between transfers, three `rsp_valid` pulses.
- Assert `presetn` low during ACCESS -> `psel`/`penable`/`rsp_valid` 0 immediately; after release `cmd_ready`=1 and no stale response issued.
